uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 156 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// ASCII command parser for a UART byte stream: "F<8 hex>\r" loads the NCO tuning
// word, "G<2 hex>\r" loads the gain; malformed or stalled commands pulse o_Err.
module uart_cmd_parser #(
  parameter logic [31:0] FREQ_DEFAULT = 32'h0147AE14,
  parameter logic [7:0]  GAIN_DEFAULT = 8'h40,
  parameter logic [23:0] TIMEOUT_CLKS = 24'd1000000
) (
  input  logic        osc_clk,
  input  logic        i_Reset,
  // i_Rx_DV is a one-cycle strobe with no back-pressure: every cycle it is high
  // delivers exactly one byte on i_Rx_Byte, and that byte is always consumed.
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [31:0] o_Freq_Word,
  output logic        o_Freq_Valid,
  output logic [7:0]  o_Gain,
  output logic        o_Gain_Valid,
  output logic        o_Err,
  output logic [1:0]  o_Dbg_State
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEX     = 2'd1,
    S_WAIT_CR = 2'd2
  } state_e;

  localparam logic [7:0] CH_CR = 8'h0D;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        tgt_gain_q, tgt_gain_d;
  logic [23:0] tmo_q, tmo_d;
  logic [31:0] freq_q, freq_d;
  logic [7:0]  gain_q, gain_d;
  logic        fv_q, fv_d, gv_q, gv_d, err_q, err_d;

  logic [4:0]  hex_dec;
  logic        is_cmd_f, is_cmd_g, timeout_hit;

  // Returns {is_hex, nibble}; letters map via their low nibble plus 9.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39)
      return {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      return {1'b1, b[3:0] + 4'd9};
    else
      return 5'd0;
  endfunction

  always_comb begin
    hex_dec     = hex_decode(i_Rx_Byte);
    is_cmd_f    = (i_Rx_Byte == 8'h46) || (i_Rx_Byte == 8'h66);
    is_cmd_g    = (i_Rx_Byte == 8'h47) || (i_Rx_Byte == 8'h67);
    timeout_hit = !i_Rx_DV && (tmo_q == TIMEOUT_CLKS - 24'd1);

    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    tgt_gain_d = tgt_gain_q;
    tmo_d      = tmo_q;
    freq_d     = freq_q;
    gain_d     = gain_q;
    fv_d       = 1'b0;
    gv_d       = 1'b0;
    err_d      = 1'b0;

    // Idle-gap counter saturates at the abort threshold instead of wrapping.
    if (state_q == S_IDLE || i_Rx_DV)
      tmo_d = '0;
    else if (tmo_q != TIMEOUT_CLKS - 24'd1)
      tmo_d = tmo_q + 24'd1;

    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && (is_cmd_f || is_cmd_g)) begin
          acc_d      = '0;
          cnt_d      = '0;
          tgt_gain_d = is_cmd_g;
          state_d    = S_HEX;
        end
      end
      S_HEX: begin
        if (i_Rx_DV) begin
          if (hex_dec[4]) begin
            acc_d = {acc_q[27:0], hex_dec[3:0]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == (tgt_gain_q ? 4'd2 : 4'd8))
              state_d = S_WAIT_CR;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_CR: begin
        if (i_Rx_DV) begin
          state_d = S_IDLE;
          if (i_Rx_Byte == CH_CR) begin
            if (tgt_gain_q) begin
              gain_d = acc_q[7:0];
              gv_d   = 1'b1;
            end else begin
              freq_d = acc_q;
              fv_d   = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      tgt_gain_q <= 1'b0;
      tmo_q      <= '0;
      freq_q     <= FREQ_DEFAULT;
      gain_q     <= GAIN_DEFAULT;
      fv_q       <= 1'b0;
      gv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      tgt_gain_q <= tgt_gain_d;
      tmo_q      <= tmo_d;
      freq_q     <= freq_d;
      gain_q     <= gain_d;
      fv_q       <= fv_d;
      gv_q       <= gv_d;
      err_q      <= err_d;
    end
  end

  assign o_Freq_Word  = freq_q;
  assign o_Freq_Valid = fv_q;
  assign o_Gain       = gain_q;
  assign o_Gain_Valid = gv_q;
  assign o_Err        = err_q;
  assign o_Dbg_State  = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed command strings plus random command traffic,
// checked cycle by cycle against a string-level model of the command grammar.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int          T      = 40;
  localparam logic [31:0] F_DEF  = 32'h0147AE14;
  localparam logic [7:0]  G_DEF  = 8'h40;

  // clock / reset / DUT
  logic        osc_clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic [31:0] o_Freq_Word;
  logic        o_Freq_Valid;
  logic [7:0]  o_Gain;
  logic        o_Gain_Valid;
  logic        o_Err;
  logic [1:0]  o_Dbg_State;

  always #5 osc_clk = ~osc_clk;

  uart_cmd_parser #(
    .FREQ_DEFAULT(F_DEF),
    .GAIN_DEFAULT(G_DEF),
    .TIMEOUT_CLKS(24'(T))
  ) dut (
    .osc_clk     (osc_clk),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Freq_Word (o_Freq_Word),
    .o_Freq_Valid(o_Freq_Valid),
    .o_Gain      (o_Gain),
    .o_Gain_Valid(o_Gain_Valid),
    .o_Err       (o_Err),
    .o_Dbg_State (o_Dbg_State)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: holds the command text received so far
  logic [7:0]  m_cmd[$];
  int          m_gap = 0;
  logic [31:0] m_freq = F_DEF;
  logic [7:0]  m_gain = G_DEF;
  logic        m_fv = 0, m_gv = 0, m_err = 0;
  bit          chk_en = 0;
  logic [32:0] exp_q[$];   // {is_gain, value} of each expected commit

  function automatic bit is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction

  function automatic int hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  task automatic model_abort();
    m_err = 1;
    m_cmd.delete();
    m_gap = 0;
  endtask

  task automatic model_step();
    int need, pos;
    logic [31:0] val;
    m_fv = 0; m_gv = 0; m_err = 0;
    if (i_Reset) begin
      chk_en = 1;
      m_cmd.delete();
      m_gap  = 0;
      m_freq = F_DEF;
      m_gain = G_DEF;
    end else if (i_Rx_DV) begin
      m_gap = 0;
      if (m_cmd.size() == 0) begin
        if (i_Rx_Byte inside {"F", "f", "G", "g"}) m_cmd.push_back(i_Rx_Byte);
      end else begin
        need = (m_cmd[0] inside {"F", "f"}) ? 8 : 2;
        pos  = m_cmd.size();
        if (pos <= need) begin
          if (is_hex(i_Rx_Byte)) m_cmd.push_back(i_Rx_Byte);
          else model_abort();
        end else if (i_Rx_Byte == 8'h0D) begin
          val = 0;
          for (int i = 1; i <= need; i++) val = val * 16 + 32'(hex_val(m_cmd[i]));
          if (need == 8) begin
            m_freq = val; m_fv = 1; exp_q.push_back({1'b0, val});
          end else begin
            m_gain = val[7:0]; m_gv = 1; exp_q.push_back({1'b1, val});
          end
          m_cmd.delete();
        end else begin
          model_abort();
        end
      end
    end else if (m_cmd.size() != 0) begin
      m_gap++;
      if (m_gap == T) model_abort();
    end
  endtask

  always @(posedge osc_clk) model_step();

  // scoreboard: per-cycle outputs and commit order
  int fv_cnt = 0, gv_cnt = 0, err_cnt = 0;
  always @(negedge osc_clk) begin
    logic [32:0] e;
    if (chk_en) begin
      check("freq_word",  o_Freq_Word, m_freq);
      check("gain",       32'(o_Gain), 32'(m_gain));
      check("freq_valid", 32'(o_Freq_Valid), 32'(m_fv));
      check("gain_valid", 32'(o_Gain_Valid), 32'(m_gv));
      check("err",        32'(o_Err), 32'(m_err));
      if (o_Freq_Valid && o_Gain_Valid) check("valid_exclusive", 32'd1, 32'd0);
      fv_cnt  += int'(o_Freq_Valid);
      gv_cnt  += int'(o_Gain_Valid);
      err_cnt += int'(o_Err);
      if (o_Freq_Valid || o_Gain_Valid) begin
        if (exp_q.size() == 0) check("unexpected_commit", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("commit_kind", 32'(o_Gain_Valid), 32'(e[32]));
          check("commit_val", o_Gain_Valid ? 32'(o_Gain) : o_Freq_Word, e[31:0]);
        end
      end
    end
  end

  // driver tasks (always called at a negedge)
  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV = 1'b1;
    i_Rx_Byte = b;
    @(negedge osc_clk);
    i_Rx_DV = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  task automatic do_reset(input int n);
    i_Reset = 1'b1;
    repeat (n) @(negedge osc_clk);
    i_Reset = 1'b0;
  endtask

  function automatic logic [7:0] hex_char(input int v, input bit lower);
    if (v < 10) return 8'(48 + v);
    return lower ? 8'(97 + v - 10) : 8'(65 + v - 10);
  endfunction

  task automatic send_q(input logic [7:0] q[$], input int max_gap);
    foreach (q[i]) begin
      send_byte(q[i]);
      idle($urandom_range(0, max_gap));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, g0, e0, kind, need, k;
    logic [7:0] cmd[$];
    logic [7:0] head[$];
    logic [7:0] tail[$];

    @(negedge osc_clk);
    do_reset(3);
    check("reset_freq", o_Freq_Word, F_DEF);
    check("reset_gain", 32'(o_Gain), 32'(G_DEF));
    check("reset_pulses", {29'd0, o_Freq_Valid, o_Gain_Valid, o_Err}, 32'd0);

    // malformed frequency command aborted, then a gain command
    e0 = err_cnt;
    send_str("F12G"); idle(3);
    check("bad_cmd_err", 32'(err_cnt - e0), 32'd1);
    check("bad_cmd_freq", o_Freq_Word, F_DEF);
    send_str("G10\r"); idle(2);
    check("after_bad_gain", 32'(o_Gain), 32'h10);

    // full frequency command
    f0 = fv_cnt;
    send_str("F0A3D70A4\r"); idle(3);
    check("freq_load", o_Freq_Word, 32'h0A3D70A4);
    check("freq_valid_cnt", 32'(fv_cnt - f0), 32'd1);
    check("freq_gain_kept", 32'(o_Gain), 32'h10);

    // two gain commands, mixed case
    g0 = gv_cnt; e0 = err_cnt;
    send_str("g7f\r"); idle(1);
    check("gain_7f", 32'(o_Gain), 32'h7F);
    send_str("G80\r"); idle(1);
    check("gain_80", 32'(o_Gain), 32'h80);
    check("gain_valid_cnt", 32'(gv_cnt - g0), 32'd2);
    check("gain_no_err", 32'(err_cnt - e0), 32'd0);

    // stalled command times out once; parser recovers
    e0 = err_cnt;
    send_str("F1234"); idle(T + 5);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    send_str("F00000001\r"); idle(2);
    check("after_timeout_freq", o_Freq_Word, 32'h1);

    // wrong terminator, then a byte landing on the exact timeout cycle
    e0 = err_cnt;
    send_str("F00000000X"); idle(2);
    check("bad_term_err", 32'(err_cnt - e0), 32'd1);
    check("bad_term_freq", o_Freq_Word, 32'h1);
    e0 = err_cnt;
    send_str("F0000000"); idle(T - 1); send_str("0\r"); idle(2);
    check("edge_timeout_freq", o_Freq_Word, 32'h0);
    check("edge_timeout_no_err", 32'(err_cnt - e0), 32'd0);

    // reset mid-command discards it silently
    f0 = fv_cnt; g0 = gv_cnt; e0 = err_cnt;
    send_str("F1234"); do_reset(1); send_str("5678\r"); idle(3);
    check("rst_mid_freq", o_Freq_Word, F_DEF);
    check("rst_mid_pulses", 32'((fv_cnt - f0) + (gv_cnt - g0) + (err_cnt - e0)), 32'd0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 11);
      cmd.delete();
      if ($urandom_range(0, 4) == 0) cmd.push_back(8'($urandom_range(0, 255)));
      need = (kind < 4 || kind >= 8) ? 8 : 2;
      cmd.push_back(need == 8 ? ($urandom_range(0, 1) ? "F" : "f")
                              : ($urandom_range(0, 1) ? "G" : "g"));
      for (int i = 0; i < need; i++)
        cmd.push_back(hex_char($urandom_range(0, 15), 1'($urandom_range(0, 1))));
      cmd.push_back(8'h0D);
      case (kind)
        7: begin
          k = $urandom_range(1, cmd.size() - 1);
          cmd[k] = 8'($urandom_range(0, 255));
          send_q(cmd, 3);
        end
        8: begin
          k = $urandom_range(1, cmd.size() - 1);
          head = cmd[0:k-1];
          send_q(head, 2);
          idle(T + $urandom_range(0, 3));
        end
        9: begin
          k = $urandom_range(1, cmd.size() - 1);
          head = cmd[0:k-1];
          tail = cmd[k:$];
          foreach (head[i]) send_byte(head[i]);
          idle(T - 1);
          foreach (tail[i]) send_byte(tail[i]);
        end
        10: begin
          k = $urandom_range(1, cmd.size() - 1);
          head = cmd[0:k-1];
          send_q(head, 2);
          do_reset($urandom_range(1, 2));
        end
        default: send_q(cmd, 3);
      endcase
      idle($urandom_range(0, 2));
    end

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
